// File: rtl/bcd_seg_display.sv
// Serial double-dabble binary-to-BCD converter driving active-low 7-segment digits.
// Optional leading-zero blanking is enabled by defining BCD_SEG_BLANK_EN.
`timescale 1ns/1ps
module bcd_seg_display #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  in_valid,
    input  logic [WIDTH-1:0]      in_value,
    output logic                  in_ready,
    output logic [7*DIGITS-1:0]   seg,
    output logic                  done,
    output logic                  overflow
);

    localparam int              BCD_W     = 4 * DIGITS;
    localparam int              CNT_W     = $clog2(WIDTH + 1);
    localparam logic [31:0]     MAX_VAL   = 32'(10 ** DIGITS - 1);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    localparam logic [6:0] SEG_ZERO  = 7'b1000000;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
`ifdef BCD_SEG_BLANK_EN
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
`endif

    typedef enum logic [1:0] {IDLE, SHIFT, LATCH} state_t;

    state_t             state_reg, state_next;
    logic [WIDTH-1:0]   shreg_reg;
    logic [BCD_W-1:0]   bcd_reg;
    logic [BCD_W-1:0]   bcd_adj;
    logic [CNT_W-1:0]   step_reg;
    logic               ovf_pend_reg;
    logic               done_reg;
    logic               overflow_reg;

    function automatic logic [6:0] digit_seg(input logic [3:0] nib);
        case (nib)
            4'd0:    digit_seg = 7'b1000000;
            4'd1:    digit_seg = 7'b1111001;
            4'd2:    digit_seg = 7'b0100100;
            4'd3:    digit_seg = 7'b0110000;
            4'd4:    digit_seg = 7'b0011001;
            4'd5:    digit_seg = 7'b0010010;
            4'd6:    digit_seg = 7'b0000010;
            4'd7:    digit_seg = 7'b1111000;
            4'd8:    digit_seg = 7'b0000000;
            4'd9:    digit_seg = 7'b0011000;
            default: digit_seg = SEG_DASH;
        endcase
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_reg <= IDLE;
        else          state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (in_valid) state_next = SHIFT;
            SHIFT:   if (step_reg == LAST_STEP) state_next = LATCH;
            LATCH:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready = (state_reg == IDLE);
    end

    // Add-3 correction applied to every nibble before each shift.
    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
            assign bcd_adj[4*gi +: 4] = (bcd_reg[4*gi +: 4] >= 4'd5)
                                        ? bcd_reg[4*gi +: 4] + 4'd3
                                        : bcd_reg[4*gi +: 4];
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shreg_reg    <= '0;
            bcd_reg      <= '0;
            step_reg     <= '0;
            ovf_pend_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: if (in_valid) begin
                    shreg_reg    <= in_value;
                    bcd_reg      <= '0;
                    step_reg     <= '0;
                    ovf_pend_reg <= ({{(32-WIDTH){1'b0}}, in_value} > MAX_VAL);
                end
                SHIFT: begin
                    // Carry out of the top nibble is dropped; ovf_pend covers that case.
                    bcd_reg   <= {bcd_adj[BCD_W-2:0], shreg_reg[WIDTH-1]};
                    shreg_reg <= shreg_reg << 1;
                    step_reg  <= step_reg + 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            done_reg     <= 1'b0;
            overflow_reg <= 1'b0;
        end else begin
            done_reg <= (state_reg == LATCH);
            if (state_reg == LATCH) overflow_reg <= ovf_pend_reg;
        end
    end

    assign done     = done_reg;
    assign overflow = overflow_reg;

`ifdef BCD_SEG_BLANK_EN
    // lead_zero[gi]: this nibble and every nibble above it are zero.
    logic [DIGITS:0] lead_zero;
    assign lead_zero[DIGITS] = 1'b1;
    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_lz
            assign lead_zero[gi] = (bcd_reg[4*gi +: 4] == 4'd0) && lead_zero[gi+1];
        end
    endgenerate
`endif

    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_dig
            logic [6:0] seg_reg;
            logic [6:0] seg_next;
`ifdef BCD_SEG_BLANK_EN
            localparam logic [6:0] RST_SEG = (gi == 0) ? SEG_ZERO : SEG_BLANK;
            always_comb begin
                if (ovf_pend_reg)                  seg_next = SEG_DASH;
                else if (gi != 0 && lead_zero[gi]) seg_next = SEG_BLANK;
                else                               seg_next = digit_seg(bcd_reg[4*gi +: 4]);
            end
`else
            localparam logic [6:0] RST_SEG = SEG_ZERO;
            always_comb begin
                if (ovf_pend_reg) seg_next = SEG_DASH;
                else              seg_next = digit_seg(bcd_reg[4*gi +: 4]);
            end
`endif
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n)               seg_reg <= RST_SEG;
                else if (state_reg == LATCH) seg_reg <= seg_next;
            end
            assign seg[7*gi +: 7] = seg_reg;
        end
    endgenerate

endmodule

// File: tb/tb_bcd_seg_display.sv
// Scoreboard bench for bcd_seg_display: three instances (8/3, 4/2, 8/2) driven with directed vectors.
`timescale 1ns/1ps
module tb_bcd_seg_display;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    logic        a_valid, a_ready, a_done, a_ovf;
    logic [7:0]  a_value;
    logic [20:0] a_seg;
    logic        b_valid, b_ready, b_done, b_ovf;
    logic [3:0]  b_value;
    logic [13:0] b_seg;
    logic        c_valid, c_ready, c_done, c_ovf;
    logic [7:0]  c_value;
    logic [13:0] c_seg;

    bcd_seg_display #(.WIDTH(8), .DIGITS(3)) u_dut_a (
        .clk(clk), .reset_n(reset_n), .in_valid(a_valid), .in_value(a_value),
        .in_ready(a_ready), .seg(a_seg), .done(a_done), .overflow(a_ovf));
    bcd_seg_display #(.WIDTH(4), .DIGITS(2)) u_dut_b (
        .clk(clk), .reset_n(reset_n), .in_valid(b_valid), .in_value(b_value),
        .in_ready(b_ready), .seg(b_seg), .done(b_done), .overflow(b_ovf));
    bcd_seg_display #(.WIDTH(8), .DIGITS(2)) u_dut_c (
        .clk(clk), .reset_n(reset_n), .in_valid(c_valid), .in_value(c_value),
        .in_ready(c_ready), .seg(c_seg), .done(c_done), .overflow(c_ovf));

    typedef struct {
        logic [20:0] seg;
        logic        ovf;
        int          cyc;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    exp_t qc[$];
    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    localparam logic [6:0] DASH  = 7'b0111111;
    localparam logic [6:0] BLANK = 7'b1111111;

    function automatic logic [6:0] pat(input int d);
        case (d)
            0: pat = 7'b1000000;  1: pat = 7'b1111001;
            2: pat = 7'b0100100;  3: pat = 7'b0110000;
            4: pat = 7'b0011001;  5: pat = 7'b0010010;
            6: pat = 7'b0000010;  7: pat = 7'b1111000;
            8: pat = 7'b0000000;  9: pat = 7'b0011000;
            default: pat = DASH;
        endcase
    endfunction

    // Reference built from integer divide/modulo of the decimal value.
    function automatic logic [20:0] model(input int v, input int digits);
        logic [20:0] r;
        int p;
        bit ovf;
        r = '0;
        p = 1;
        ovf = (v > (10 ** digits) - 1);
        for (int d = 0; d < digits; d++) begin
            r[7*d +: 7] = ovf ? DASH : pat((v / p) % 10);
`ifdef BCD_SEG_BLANK_EN
            if (!ovf && d > 0 && v < p) r[7*d +: 7] = BLANK;
`endif
            p = p * 10;
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    function automatic logic get_ready(input int sel);
        case (sel)
            0:       get_ready = a_ready;
            1:       get_ready = b_ready;
            default: get_ready = c_ready;
        endcase
    endfunction

    task automatic drive(input int sel, input logic vld, input logic [7:0] v);
        case (sel)
            0:       begin a_valid = vld; a_value = v;      end
            1:       begin b_valid = vld; b_value = v[3:0]; end
            default: begin c_valid = vld; c_value = v;      end
        endcase
    endtask

    task automatic send(input int sel, input int v, input bit track, input bit hand,
                        input logic [20:0] hseg, input logic hovf, output int acc);
        int n;
        int digits;
        logic [7:0] vb;
        exp_t e;
        vb = v[7:0];
        digits = (sel == 0) ? 3 : 2;
        n = 0;
        acc = -1;
        @(negedge clk);
        drive(sel, 1'b1, vb);
        while (!get_ready(sel) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!get_ready(sel)) begin
            check("accept_timeout", 32'd0, 32'd1);
            drive(sel, 1'b0, vb);
        end else begin
            @(posedge clk);
            #1;
            acc = cyc;
            if (track) begin
                e.seg = hand ? hseg : model(v, digits);
                e.ovf = hand ? hovf : (v > (10 ** digits) - 1);
                e.cyc = cyc;
                case (sel)
                    0:       qa.push_back(e);
                    1:       qb.push_back(e);
                    default: qc.push_back(e);
                endcase
            end
            // Scramble the input after acceptance; it must not affect the conversion.
            drive(sel, 1'b0, ~vb);
            $display("send dut%0d value=%0d accepted at cycle %0d", sel, v, acc);
        end
    endtask

    task automatic pop(input int sel, input logic [20:0] s, input logic o, input int lat);
        exp_t e;
        int sz;
        case (sel)
            0:       sz = qa.size();
            1:       sz = qb.size();
            default: sz = qc.size();
        endcase
        if (sz == 0) begin
            check($sformatf("dut%0d_unexpected_done", sel), 32'd1, 32'd0);
        end else begin
            case (sel)
                0:       e = qa.pop_front();
                1:       e = qb.pop_front();
                default: e = qc.pop_front();
            endcase
            check($sformatf("dut%0d_seg", sel), 32'(s), 32'(e.seg));
            check($sformatf("dut%0d_overflow", sel), 32'(o), 32'(e.ovf));
            check($sformatf("dut%0d_latency", sel), 32'(cyc - e.cyc), 32'(lat));
            $display("done dut%0d seg=%06h ovf=%0b at cycle %0d", sel, s, o, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (a_done) pop(0, a_seg, a_ovf, 9);
        if (b_done) pop(1, {7'b0, b_seg}, b_ovf, 5);
        if (c_done) pop(2, {7'b0, c_seg}, c_ovf, 9);
    end

    task automatic drain();
        int n;
        n = 0;
        while ((qa.size() + qb.size() + qc.size()) != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("drain_pending", 32'(qa.size() + qb.size() + qc.size()), 32'd0);
        repeat (2) @(negedge clk);
    endtask

    int acc0, acc1;

    initial begin
        reset_n = 1'b0;
        a_valid = 1'b0; a_value = '0;
        b_valid = 1'b0; b_value = '0;
        c_valid = 1'b0; c_value = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("a_reset_seg", 32'(a_seg), 32'(model(0, 3)));
        check("b_reset_seg", 32'(b_seg), 32'(model(0, 2)));
        check("c_reset_seg", 32'(c_seg), 32'(model(0, 2)));
        check("a_reset_done", 32'(a_done), 32'd0);
        check("a_reset_ovf", 32'(a_ovf), 32'd0);
        check("a_reset_ready", 32'(a_ready), 32'd1);
        reset_n = 1'b1;

        // 255 on 8-bit/3-digit: busy for E1..E9, ready again after.
        send(0, 255, 1, 1, {7'b0100100, 7'b0010010, 7'b0010010}, 1'b0, acc0);
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            check("a_ready_busy", 32'(a_ready), 32'd0);
        end
        @(negedge clk);
        check("a_ready_after", 32'(a_ready), 32'd1);

        // Full sweep on 4-bit/2-digit, back-to-back.
        for (int v = 0; v < 16; v++) send(1, v, 1, 0, '0, 1'b0, acc0);

        // Decimal overflow boundary on 8-bit/2-digit.
        send(2, 100, 1, 1, {7'b0, DASH, DASH}, 1'b1, acc0);
        send(2, 99, 1, 1, {7'b0, 7'b0011000, 7'b0011000}, 1'b0, acc0);
        drain();

        // Busy rejection: 77 presented during SHIFT is accepted only at E_WIDTH+2.
        send(0, 42, 1, 0, '0, 1'b0, acc0);
        send(0, 77, 1, 0, '0, 1'b0, acc1);
        check("a_busy_accept_gap", 32'(acc1 - acc0), 32'd10);
        drain();

        // Reset at step 4 of a 200 conversion abandons it without a done pulse.
        send(0, 200, 0, 0, '0, 1'b0, acc0);
        repeat (4) @(posedge clk);
        #1 reset_n = 1'b0;
        #1;
        check("a_midreset_seg", 32'(a_seg), 32'(model(0, 3)));
        check("a_midreset_ovf", 32'(a_ovf), 32'd0);
        repeat (2) begin
            @(negedge clk);
            check("a_midreset_done", 32'(a_done), 32'd0);
        end
        reset_n = 1'b1;
        @(negedge clk);
        check("a_ready_post_reset", 32'(a_ready), 32'd1);
        repeat (12) begin
            @(negedge clk);
            check("a_no_done_after_abort", 32'(a_done), 32'd0);
        end
        send(0, 5, 1, 0, '0, 1'b0, acc0);

        // Small values exercise leading digits (blanked when enabled).
        send(0, 7, 1, 0, '0, 1'b0, acc0);
        send(0, 0, 1, 0, '0, 1'b0, acc0);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
